// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD chain counter and its digit cells.
// Per-digit moduli are packed 4 bits per digit into a 32-bit vector.
package bcd_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX    = 4'h9;
    localparam int   MAX_DIGITS = 8;

    // Extract the modulus of digit idx from a packed modulus vector.
    function automatic bcd_t mod_of(input logic [31:0] mod_vec, input int idx);
        return mod_vec[4*idx +: 4];
    endfunction

    // Force a digit into 0..modulus-1 so a bad load cannot create an illegal state.
    function automatic bcd_t clamp_digit(input bcd_t val, input bcd_t modulus);
        if (val >= modulus) begin
            return modulus - 4'd1;
        end
        return val;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit with a per-digit modulus, up/down stepping, clear and clamped load.
// terminal flags the value at which the next step rolls into the neighbouring digit.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic       dir,
    input  logic       ld,
    input  logic [3:0] ld_val,
    input  logic [3:0] mod,
    output logic [3:0] value,
    output logic       terminal
);

    bcd_t value_reg;
    bcd_t value_next;
    bcd_t top_val;

    assign top_val = mod - 4'd1;

    always_comb begin
        value_next = value_reg;
        if (clr) begin
            value_next = '0;
        end else if (ld) begin
            value_next = clamp_digit(ld_val, mod);
        end else if (en) begin
            if (dir) begin
                value_next = (value_reg == 4'd0) ? top_val : value_reg - 4'd1;
            end else begin
                value_next = (value_reg == top_val) ? 4'd0 : value_reg + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_reg <= '0;
        end else begin
            value_reg <= value_next;
        end
    end

    assign value    = value_reg;
    assign terminal = dir ? (value_reg == 4'd0) : (value_reg == top_val);

endmodule

// File: rtl/bcd_chain_counter.sv
// Fully synchronous multi-digit BCD counter with per-digit moduli, up/down,
// load/clear, lap display hold and an optional countdown stop-at-zero mode.
module bcd_chain_counter
    import bcd_pkg::*;
#(
    parameter int          NUM_DIGITS = 4,
    parameter logic [31:0] MOD_VECTOR = 32'h0000_6A6A,
    parameter int          TIMER_STOP = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tick,
    input  logic                    run,
    input  logic                    down,
    input  logic                    clear,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    input  logic                    lap,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [4*NUM_DIGITS-1:0] disp_digits,
    output logic                    carry_out,
    output logic                    all_zero,
    output logic                    done
);

    localparam int   W        = 4 * NUM_DIGITS;
    localparam logic TIMER_EN = (TIMER_STOP != 0);

    logic [NUM_DIGITS:0]   chain_en;
    logic [NUM_DIGITS-1:0] term;
    logic [W-1:0]          one_val;

    logic         count_req;
    logic         timer_hold;
    logic         count_go;
    logic         at_one;
    logic         lap_rise;

    logic         carry_reg,  carry_next;
    logic         done_reg,   done_next;
    logic         lap_d_reg;
    logic [W-1:0] held_reg;

    assign one_val   = W'(1);
    assign all_zero  = (digits == '0);
    assign at_one    = (digits == one_val);

    // In timer mode a down-count is frozen once expired or already at zero.
    assign count_req  = run & tick;
    assign timer_hold = TIMER_EN & down & (done_reg | all_zero);
    assign count_go   = count_req & ~timer_hold;

    assign chain_en[0] = count_go;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            bcd_digit_cell u_cell (
                .clk      (clk),
                .reset    (reset),
                .clr      (clear),
                .en       (chain_en[gi] & ~load),
                .dir      (down),
                .ld       (load),
                .ld_val   (load_value[4*gi +: 4]),
                .mod      (mod_of(MOD_VECTOR, gi)),
                .value    (digits[4*gi +: 4]),
                .terminal (term[gi])
            );
            assign chain_en[gi+1] = chain_en[gi] & term[gi];
        end
    endgenerate

    always_comb begin
        carry_next = 1'b0;
        done_next  = done_reg;
        if (clear || load) begin
            done_next = 1'b0;
        end else begin
            // Every digit terminal while enabled means the whole chain wraps.
            carry_next = chain_en[NUM_DIGITS];
            if (TIMER_EN && down && count_req && !done_reg && (all_zero || at_one)) begin
                done_next = 1'b1;
            end
        end
    end

    assign lap_rise = lap & ~lap_d_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            carry_reg <= 1'b0;
            done_reg  <= 1'b0;
            lap_d_reg <= 1'b0;
            held_reg  <= '0;
        end else begin
            carry_reg <= carry_next;
            done_reg  <= done_next;
            lap_d_reg <= lap;
            if (lap_rise) begin
                held_reg <= digits;
            end
        end
    end

    // During the first lap cycle the capture has not landed yet, so show live digits.
    assign disp_digits = lap ? (lap_rise ? digits : held_reg) : digits;
    assign carry_out   = carry_reg;
    assign done        = TIMER_EN & done_reg;

endmodule

// File: tb/tb_bcd_chain_counter.sv
// Directed bench: a timer-mode and a free-running instance share one stimulus
// stream; every expected value is hand-computed for the 59:59 default layout.
module tb_bcd_chain_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick, run, down, clear, load, lap;
    logic [15:0] load_value;

    logic [15:0] t_digits, t_disp, f_digits, f_disp;
    logic        t_carry, t_zero, t_done, f_carry, f_zero, f_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcd_chain_counter #(.NUM_DIGITS(4), .MOD_VECTOR(32'h0000_6A6A), .TIMER_STOP(1)) u_timer (
        .clk(clk), .reset(reset), .tick(tick), .run(run), .down(down),
        .clear(clear), .load(load), .load_value(load_value), .lap(lap),
        .digits(t_digits), .disp_digits(t_disp), .carry_out(t_carry),
        .all_zero(t_zero), .done(t_done)
    );

    bcd_chain_counter #(.NUM_DIGITS(4), .MOD_VECTOR(32'h0000_6A6A), .TIMER_STOP(0)) u_free (
        .clk(clk), .reset(reset), .tick(tick), .run(run), .down(down),
        .clear(clear), .load(load), .load_value(load_value), .lap(lap),
        .digits(f_digits), .disp_digits(f_disp), .carry_out(f_carry),
        .all_zero(f_zero), .done(f_done)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        $display("txn t=%0t tick=%0b run=%0b down=%0b clr=%0b ld=%0b lap=%0b | timer=%h c=%0b d=%0b | free=%h c=%0b",
                 $time, tick, run, down, clear, load, lap, t_digits, t_carry, t_done, f_digits, f_carry);
    endtask

    task automatic do_load(input logic [15:0] v);
        load_value = v;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        tick = 0; run = 0; down = 0; clear = 0; load = 0; lap = 0;
        load_value = '0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_digits", {16'h0, t_digits}, 32'h0);
        check_val("rst_disp",   {16'h0, t_disp},   32'h0);
        check_val("rst_carry",  {31'h0, t_carry},  32'h0);
        check_val("rst_done",   {31'h0, t_done},   32'h0);
        check_val("rst_zero",   {31'h0, t_zero},   32'h1);
        reset = 1'b0;
        step();

        // Full-chain wrap going up
        run = 1'b1;
        do_load(16'h5959);
        check_val("load5959", {16'h0, t_digits}, 32'h5959);
        check_val("load5959_nz", {31'h0, t_zero}, 32'h0);
        do_tick();
        check_val("wrap_up",       {16'h0, t_digits}, 32'h0000);
        check_val("wrap_up_carry", {31'h0, t_carry},  32'h1);
        check_val("wrap_up_zero",  {31'h0, t_zero},   32'h1);
        step();
        check_val("carry_1cyc", {31'h0, t_carry}, 32'h0);

        // Borrow through digits going down
        down = 1'b1;
        do_load(16'h0100);
        do_tick();
        check_val("borrow_t", {16'h0, t_digits}, 32'h0059);
        check_val("borrow_f", {16'h0, f_digits}, 32'h0059);
        do_load(16'h0000);
        do_tick();
        check_val("down_wrap_f",   {16'h0, f_digits}, 32'h5959);
        check_val("down_wrap_fc",  {31'h0, f_carry},  32'h1);
        check_val("down_wrap_fd",  {31'h0, f_done},   32'h0);
        check_val("zero_hold_t",   {16'h0, t_digits}, 32'h0000);
        check_val("zero_hold_td",  {31'h0, t_done},   32'h1);
        check_val("zero_hold_tc",  {31'h0, t_carry},  32'h0);

        // Timer expiry and stop
        do_load(16'h0002);
        check_val("load_clr_done", {31'h0, t_done}, 32'h0);
        do_tick();
        check_val("timer_1", {16'h0, t_digits}, 32'h0001);
        check_val("timer_1_done", {31'h0, t_done}, 32'h0);
        do_tick();
        check_val("timer_0",       {16'h0, t_digits}, 32'h0000);
        check_val("timer_0_done",  {31'h0, t_done},   32'h1);
        check_val("timer_0_carry", {31'h0, t_carry},  32'h0);
        check_val("free_0_carry",  {31'h0, f_carry},  32'h0);
        for (int i = 0; i < 3; i++) do_tick();
        check_val("timer_stuck",  {16'h0, t_digits}, 32'h0000);
        check_val("timer_stuckd", {31'h0, t_done},   32'h1);
        check_val("free_3down",   {16'h0, f_digits}, 32'h5957);
        down = 1'b0;
        do_tick();
        check_val("up_after_done",  {16'h0, t_digits}, 32'h0001);
        check_val("up_keeps_done",  {31'h0, t_done},   32'h1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_val("clear_done", {31'h0, t_done},   32'h0);
        check_val("clear_dig",  {16'h0, t_digits}, 32'h0000);

        // Priority and clamping
        do_load(16'h0033);
        clear = 1'b1; load = 1'b1; tick = 1'b1; load_value = 16'h1234;
        step();
        clear = 1'b0; load = 1'b0; tick = 1'b0;
        check_val("prio_clear", {16'h0, t_digits}, 32'h0000);
        do_load(16'h7B00);
        check_val("clamp", {16'h0, t_digits}, 32'h5900);
        run = 1'b0;
        for (int i = 0; i < 5; i++) do_tick();
        check_val("run_off", {16'h0, t_digits}, 32'h5900);
        run = 1'b1;

        // Lap hold while counting
        do_load(16'h0010);
        lap = 1'b1;
        for (int i = 0; i < 3; i++) do_tick();
        check_val("lap_disp", {16'h0, t_disp},   32'h0010);
        check_val("lap_live", {16'h0, t_digits}, 32'h0013);
        lap = 1'b0;
        #1;
        check_val("lap_release", {16'h0, t_disp}, 32'h0013);

        // Async reset mid-cycle
        do_load(16'h1234);
        check_val("pre_reset", {16'h0, t_digits}, 32'h1234);
        #2 reset = 1'b1;
        #1;
        check_val("arst_digits", {16'h0, t_digits}, 32'h0000);
        check_val("arst_disp",   {16'h0, t_disp},   32'h0000);
        check_val("arst_free",   {16'h0, f_digits}, 32'h0000);
        check_val("arst_zero",   {31'h0, t_zero},   32'h1);
        #1 reset = 1'b0;
        do_tick();
        check_val("post_reset", {16'h0, t_digits}, 32'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
